// File: rtl/sdg_seq_checker.sv
// sdg_seq_checker: receive-side checker for the self-decimated LFSR stream.
// Optional macro SDG_CHK_AUTORESYNC_EN: one-cycle FAIL, then auto re-acquire.
module sdg_seq_checker #(
    parameter int LOCK_N  = 64,
    parameter int ERR_MAX = 8,
    parameter int WIN     = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic             din,
    input  logic             din_vld,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam int WIN_W = $clog2(WIN + 1);
    localparam int WE_W  = $clog2(ERR_MAX + 1);

    localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_N);
    localparam logic [WIN_W-1:0] WIN_V  = WIN_W'(WIN);
    localparam logic [WE_W-1:0]  WERR_V = WE_W'(ERR_MAX);
    localparam logic [CNT_W-1:0] TERR_V = CNT_W'(ERR_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCK,
        ST_FAIL
    } state_t;

    function automatic logic [31:0] f_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    state_t           r_state;
    logic [31:0]      r_s;
`ifdef SDG_CHK_AUTORESYNC_EN
    logic [31:0]      r_seed;
`endif
    logic [RUN_W-1:0] r_run;
    logic [WIN_W-1:0] r_win;
    logic [WE_W-1:0]  r_werr;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_busy;
    logic             r_locked;
    logic             r_fail;
    logic             r_pulse;

    logic [31:0]      w_seed_eff;
    logic [31:0]      w_s_adv;
    logic             w_miss;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [RUN_W-1:0] w_run_inc;
    logic [WIN_W-1:0] w_win_inc;
    logic [WE_W-1:0]  w_werr_inc;

    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    assign w_seed_eff = (seed == 32'h0) ? 32'h0000_0001 : seed;
    // Decimation: odd parity of the current state means a double step.
    assign w_s_adv    = (^r_s) ? f_step(f_step(r_s)) : f_step(r_s);
    assign w_miss     = din ^ r_s[31];
    assign w_cnt_inc  = (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
    assign w_run_inc  = r_run + 1'b1;
    assign w_win_inc  = r_win + 1'b1;
    assign w_werr_inc = r_werr + 1'b1;

    assign busy      = r_busy;
    assign locked    = r_locked;
    assign fail      = r_fail;
    assign err_pulse = r_pulse;
    assign err_cnt   = r_err_cnt;

    // Checker FSM, replica LFSR, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_s       <= 32'h0000_0001;
`ifdef SDG_CHK_AUTORESYNC_EN
            r_seed    <= 32'h0000_0001;
`endif
            r_run     <= '0;
            r_win     <= '0;
            r_werr    <= '0;
            r_err_cnt <= '0;
            r_busy    <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (start) begin
                r_state   <= ST_ACQ;
                r_s       <= w_seed_eff;
`ifdef SDG_CHK_AUTORESYNC_EN
                r_seed    <= w_seed_eff;
`endif
                r_run     <= '0;
                r_win     <= '0;
                r_werr    <= '0;
                r_err_cnt <= '0;
                r_busy    <= 1'b1;
                r_locked  <= 1'b0;
                r_fail    <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                    end
                    ST_ACQ: begin
                        if (din_vld) begin
                            r_s <= w_s_adv;
                            if (w_miss) begin
                                r_pulse   <= 1'b1;
                                r_err_cnt <= w_cnt_inc;
                                r_run     <= '0;
                                if (w_cnt_inc >= TERR_V) begin
                                    r_state <= ST_FAIL;
                                    r_busy  <= 1'b0;
                                    r_fail  <= 1'b1;
                                end
                            end else begin
                                r_run <= w_run_inc;
                                if (w_run_inc == LOCK_V) begin
                                    r_state  <= ST_LOCK;
                                    r_locked <= 1'b1;
                                    r_win    <= '0;
                                    r_werr   <= '0;
                                end
                            end
                        end
                    end
                    ST_LOCK: begin
                        if (din_vld) begin
                            r_s <= w_s_adv;
                            if (w_miss) begin
                                r_pulse   <= 1'b1;
                                r_err_cnt <= w_cnt_inc;
                            end
                            if (w_miss && (w_werr_inc == WERR_V)) begin
                                r_state  <= ST_FAIL;
                                r_busy   <= 1'b0;
                                r_locked <= 1'b0;
                                r_fail   <= 1'b1;
                            end else if (w_win_inc == WIN_V) begin
                                r_win  <= '0;
                                r_werr <= '0;
                            end else begin
                                r_win <= w_win_inc;
                                if (w_miss) begin
                                    r_werr <= w_werr_inc;
                                end
                            end
                        end
                    end
                    ST_FAIL: begin
`ifdef SDG_CHK_AUTORESYNC_EN
                        r_state <= ST_ACQ;
                        r_s     <= r_seed;
                        r_run   <= '0;
                        r_win   <= '0;
                        r_werr  <= '0;
                        r_busy  <= 1'b1;
                        r_fail  <= 1'b0;
`endif
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdg_seq_checker.sv
// tb_sdg_seq_checker: randomized bench for sdg_seq_checker against a
// sample-level reference model driven by a precomputed expected stream.
module tb_sdg_seq_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] seed;
    logic        din;
    logic        din_vld;
    logic        busy;
    logic        locked;
    logic        fail;
    logic        err_pulse;
    logic [15:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    sdg_seq_checker dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .din       (din),
        .din_vld   (din_vld),
        .busy      (busy),
        .locked    (locked),
        .fail      (fail),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: expected stream as a queue, mode as a plain int.
    // mode 0 idle, 1 acquiring, 2 locked, 3 failed.
    bit          exp_q[$];
    bit [31:0]   g_s = 32'h1;
    bit [31:0]   m_seed = 32'h1;
    int          m_mode = 0;
    int          m_idx = 0;
    int          m_run = 0;
    int          m_win = 0;
    int          m_werr = 0;
    int          m_err = 0;
    bit          m_pulse = 0;

    function automatic bit [31:0] lfsr_next(input bit [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic bit m_exp();
        bit p;
        while (exp_q.size() <= m_idx) begin
            exp_q.push_back(g_s[31]);
            p = ^g_s;
            g_s = lfsr_next(g_s);
            if (p) g_s = lfsr_next(g_s);
        end
        return exp_q[m_idx];
    endfunction

    function automatic void m_restart();
        exp_q.delete();
        g_s = m_seed;
        m_idx = 0;
        m_run = 0;
        m_win = 0;
        m_werr = 0;
    endfunction

    function automatic void m_reset();
        m_mode = 0;
        m_seed = 32'h1;
        m_restart();
        m_err = 0;
        m_pulse = 0;
    endfunction

    function automatic void m_step(bit st, bit [31:0] sd, bit vld, bit d);
        bit miss;
        m_pulse = 0;
        if (st) begin
            m_seed = (sd == 0) ? 32'h1 : sd;
            m_restart();
            m_err = 0;
            m_mode = 1;
        end else if (m_mode == 3) begin
`ifdef SDG_CHK_AUTORESYNC_EN
            m_restart();
            m_mode = 1;
`endif
        end else if ((m_mode == 1 || m_mode == 2) && vld) begin
            miss = (d != m_exp());
            m_idx++;
            if (miss) begin
                m_pulse = 1;
                m_err++;
            end
            if (m_mode == 1) begin
                m_run = miss ? 0 : m_run + 1;
                if (miss && m_err >= 8) m_mode = 3;
                else if (m_run == 64) begin
                    m_mode = 2;
                    m_win = 0;
                    m_werr = 0;
                end
            end else begin
                m_win++;
                if (miss) m_werr++;
                if (m_werr >= 8) m_mode = 3;
                else if (m_win == 256) begin
                    m_win = 0;
                    m_werr = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int sat;
        sat = (m_err > 65535) ? 65535 : m_err;
        chk({tag, ".busy"}, busy, (m_mode == 1 || m_mode == 2));
        chk({tag, ".locked"}, locked, (m_mode == 2));
        chk({tag, ".fail"}, fail, (m_mode == 3));
        chk({tag, ".pulse"}, err_pulse, m_pulse);
        chk({tag, ".err_cnt"}, err_cnt, sat);
    endtask

    // One clock: drive, let the edge happen, advance model, compare.
    task automatic tick(input bit st, input bit [31:0] sd,
                        input bit vld, input bit flip);
        bit d;
        d = m_exp() ^ flip;
        start = st;
        seed = sd;
        din_vld = vld;
        din = d;
        @(posedge clk);
        m_step(st, sd, vld, d);
        #1;
        check_outputs("cyc");
        start = 1'b0;
        din_vld = 1'b0;
    endtask

    initial begin
        int cnt;
        int pulses;
        int fails;
        bit seen;
        bit [31:0] rs;

        rst = 1'b0;
        start = 1'b0;
        seed = '0;
        din = 1'b0;
        din_vld = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b1;

        // 1: clean stream, lock exactly one cycle after sample 64
        tick(1, 32'hACE1_2345, 0, 0);
        cnt = 0;
        seen = 0;
        while (cnt < 300) begin
            bit v;
            v = ($urandom % 4) != 0;
            tick(0, 0, v, 0);
            if (v) cnt++;
            if (locked && !seen) begin
                seen = 1;
                chk("t1_lock_at", cnt, 64);
            end
        end
        chk("t1_locked", locked, 1);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_fail", fail, 0);

        // 2: 7 errors per window holds lock, 8 errors fails
        tick(1, 32'hACE1_2345, 0, 0);
        for (int i = 0; i < 64; i++) tick(0, 0, 1, 0);
        chk("t2_locked", locked, 1);
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            tick(0, 0, 1, (i % 36) == 5);
            pulses += err_pulse;
        end
        chk("t2_pulses7", pulses, 7);
        chk("t2_hold", locked, 1);
        pulses = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) begin
            tick(0, 0, 1, (i % 32) == 3);
            pulses += err_pulse;
            fails += fail;
        end
        chk("t2_pulses8", pulses, 8);
        chk("t2_err_cnt", err_cnt, 15);
`ifdef SDG_CHK_AUTORESYNC_EN
        chk("t2_fail_cycles", fails, 1);
        chk("t2_busy", busy, 1);
`else
        chk("t2_fail", fail, 1);
`endif

        // 3: zero seed behaves as seed 1
        tick(1, 32'h0, 0, 0);
        for (int i = 0; i < 64; i++) tick(0, 0, 1, 0);
        chk("t3_locked", locked, 1);

        // 4: error at sample 40 restarts the run
        rs = $urandom;
        tick(1, rs, 0, 0);
        for (int i = 0; i < 39; i++) tick(0, 0, 1, 0);
        tick(0, 0, 1, 1);
        for (int i = 0; i < 63; i++) tick(0, 0, 1, 0);
        chk("t4_not_yet", locked, 0);
        tick(0, 0, 1, 0);
        chk("t4_locked", locked, 1);
        chk("t4_err_cnt", err_cnt, 1);

        // 5: start beats din_vld; async reset mid-stream
        tick(1, rs, 1, 0);
        chk("t5_locked", locked, 0);
        chk("t5_busy", busy, 1);
        for (int i = 0; i < 20; i++) tick(0, 0, 1, ($urandom % 5) == 0);
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        check_outputs("t5_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;

`ifdef SDG_CHK_AUTORESYNC_EN
        // 6: one-cycle FAIL, then relock with err_cnt retained
        rs = $urandom;
        tick(1, rs, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 1);
        chk("t6_fail", fail, 1);
        tick(0, 0, 1, 0);
        chk("t6_fail_gone", fail, 0);
        chk("t6_busy", busy, 1);
        for (int i = 0; i < 64; i++) tick(0, 0, 1, 0);
        chk("t6_relock", locked, 1);
        chk("t6_err_cnt", err_cnt, 8);
`endif

        // random soak
        tick(1, $urandom, 0, 0);
        for (int i = 0; i < 2500; i++) begin
            bit st;
            bit [31:0] sd;
            st = ($urandom % 300) == 0;
            sd = (($urandom % 4) == 0) ? 32'h0 : $urandom;
            tick(st, sd, ($urandom % 5) != 0, ($urandom % 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdg_seq_checker.md
Name: sdg_seq_checker

Overview:
- Receive-side checker for the self-decimated pseudo-random stream.
- Holds a local replica of the generator's 32-bit LFSR, seeded from a shared seed.
- Advances the replica with the same parity-driven decimation rule as the generator.
- Compares each received bit against the prediction, counts errors and reports lock or fail status.
- Single-clock design; decimation is modelled as a 1-step or 2-step advance per sample, not as a clock mux.

Parameters:
- LOCK_N, 64: consecutive correct samples in ACQ needed to declare lock.
- ERR_MAX, 8: error count that forces FAIL. In ACQ this is total errors; in LOCKED it is errors within one window.
- WIN, 256: LOCKED error-window length, in samples.
- CNT_W, 16: width of the total error counter.

Ports:
- clk, in, 1: single system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: single-cycle pulse; loads seed and enters ACQ.
- seed, in, 32: replica seed, sampled only on start.
- din, in, 1: received stream bit.
- din_vld, in, 1: din is valid this cycle.
- busy, out, 1: FSM is in ACQ or LOCKED.
- locked, out, 1: FSM is in LOCKED.
- fail, out, 1: FSM is in FAIL.
- err_pulse, out, 1: one-cycle pulse for each mismatched sample.
- err_cnt, out, CNT_W: total mismatches since the last start; saturates.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; replica state s=32'h0000_0001.
  - All counters cleared.
  - busy=0, locked=0, fail=0, err_pulse=0, err_cnt=0.
- LFSR step function:
  - Fibonacci, shift left; polynomial x^32+x^22+x^2+x+1.
  - fb = s[31]^s[21]^s[1]^s[0]; next = {s[30:0], fb}.
- Prediction and decimation:
  - Predicted bit is s[31].
  - After each consumed sample, compute p = ^s (parity of the pre-advance state).
  - s <= step(s) if p=0; s <= step(step(s)) if p=1.
  - s does not change on cycles without a consumed sample.
- Seed load:
  - On start, s <= seed.
  - If seed==0, load 32'h0000_0001 instead, to avoid the all-zero lock-up.
- Sample consumption:
  - A sample is consumed when din_vld=1 in ACQ or LOCKED.
  - Mismatch means din != s[31].
  - All outputs are registered and reflect a sample one cycle after it is consumed.
- FSM states:
  - IDLE: waits for start; din_vld is ignored.
  - ACQ:
    - Match: run counter +1.
    - Mismatch: run counter cleared; err_cnt +1.
    - Run counter reaches LOCK_N → go to LOCKED; window counter and window errors cleared.
    - Total errors since start reach ERR_MAX → go to FAIL.
  - LOCKED:
    - Each sample increments the window counter; each mismatch increments window errors.
    - Window errors reach ERR_MAX → go to FAIL. This takes priority over window roll-over on the same sample.
    - Window counter reaches WIN → both window counter and window errors clear.
  - FAIL: sticky; samples are ignored; s is frozen.
- start from any state: reload seed, clear run, window and err_cnt, go to ACQ.
- start together with din_vld: start wins; the sample is dropped and not compared.
- err_cnt saturates at all-ones and does not wrap.
- err_pulse fires on every mismatch, including the mismatch that triggers FAIL.
- Mid-operation reset aborts immediately to the reset values above.

Optional Feature:
- Macro: SDG_CHK_AUTORESYNC_EN.
- Defined:
  - FAIL lasts exactly one cycle (fail=1 for that cycle).
  - The FSM then re-enters ACQ with s reloaded from the last captured seed; run and window counters clear.
  - err_cnt is preserved.
  - Samples arriving during the FAIL cycle are dropped.
- Undefined: FAIL is sticky until start.

Test Plan:
1. Reset, then start with seed=32'hACE1_2345. Drive 300 samples from a bit-exact generator model with the same seed → locked rises one cycle after sample 64; err_cnt=0; fail=0.
2. From lock (scenario 1), flip 8 bits spread within one 256-sample window → err_pulse fires 8 times; fail=1 after the 8th; err_cnt=8. Flip 7 per window instead → stays locked.
3. Start with seed=0 → replica matches a model seeded with 32'h0000_0001; lock at sample 64.
4. In ACQ, inject one error at sample 40 → run counter restarts; lock only after 64 further correct samples; err_cnt=1.
5. Assert start and din_vld in the same cycle while LOCKED → sample dropped, locked=0 and busy=1 next cycle. Assert rst=0 mid-stream → all outputs 0 immediately.
6. With SDG_CHK_AUTORESYNC_EN defined, force FAIL → fail high exactly one cycle, then busy=1 in ACQ. Feed a restarted model stream → relocks after 64 samples; err_cnt retained.
